rns_reconstruct: RTL and testbench

Inverse of the RNS decomposition path. It accepts the `parts` residues of one wide operand serially, one per handshake, ordered index 0 first. It rebuilds the operand with the Chinese Remainder Theorem and emits one `lwidth`-bit result. It sits at the output of the RNS-domain datapath and returns residue-domain results to full-width integers.

---
 rtl/rns_reconstruct.sv | 118 +++++++++++
 tb/tb_rns_reconstruct.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/rns_reconstruct.sv
// Serial CRT reconstruction: accepts parts residues one per handshake and emits the
// full-width integer x = (sum ((r_i*qinv_i) mod q_i) * qhat_i) mod Q.
module rns_reconstruct #(
  parameter int lwidth = 32,
  parameter int swidth = 8,
  parameter int parts  = 4,
  // CRT constant tables for the deployed modulus set; index 0 is the first residue
  parameter logic [lwidth-1:0]             q_prod   = 32'd3368562317,
  parameter logic [parts-1:0][swidth-1:0]  q_tab    = {8'd233, 8'd239, 8'd241, 8'd251},
  parameter logic [parts-1:0][swidth-1:0]  qinv_tab = {8'd209, 8'd78, 8'd119, 8'd71},
  parameter logic [parts-1:0][lwidth-1:0]  qhat_tab = {32'd14457349, 32'd14094403,
                                                       32'd13977437, 32'd13420567}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r_valid,
  input  logic [swidth-1:0] r_input,
  output logic              r_ready,
  output logic [lwidth-1:0] a_output,
  output logic              a_valid
);
  localparam int CW = $clog2(parts);
  localparam int AW = lwidth + CW;
  localparam int PW = 2 * swidth;
  localparam logic [CW:0] LAST = (CW+1)'(parts - 1);

  typedef logic [parts-1:0][PW-1:0] mu_t;

  // Barrett factors floor(2^PW / q_i), fixed at elaboration
  function automatic mu_t calc_mu();
    mu_t m;
    for (int i = 0; i < parts; i++)
      m[i] = PW'((64'd1 << PW) / 64'(q_tab[i]));
    return m;
  endfunction
  localparam mu_t MU = calc_mu();

  typedef enum logic [2:0] {S_INIT, S_LOAD, S_MODMUL, S_ACC, S_REDUCE} state_t;

  state_t            state;
  logic [AW-1:0]     acc;
  logic [CW:0]       cnt;
  logic [swidth-1:0] r_q;
  logic [swidth-1:0] y;
  logic [CW-1:0]     idx;

  logic [PW-1:0]   prod, quot, qsel, rem0, rem1, rem2;
  logic [2*PW-1:0] wide;

  assign idx = cnt[CW-1:0];

  // Quotient estimate is at most one short, so two conditional subtracts always suffice
  always_comb begin
    qsel = PW'(q_tab[idx]);
    prod = PW'(r_q) * PW'(qinv_tab[idx]);
    wide = (2*PW)'(prod) * (2*PW)'(MU[idx]);
    quot = PW'(wide >> PW);
    rem0 = prod - quot * qsel;
    rem1 = (rem0 >= qsel) ? rem0 - qsel : rem0;
    rem2 = (rem1 >= qsel) ? rem1 - qsel : rem1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INIT;
      acc      <= '0;
      cnt      <= '0;
      r_q      <= '0;
      y        <= '0;
      r_ready  <= 1'b0;
      a_output <= '0;
      a_valid  <= 1'b0;
    end else begin
      a_valid <= 1'b0;
      case (state)
        S_INIT: begin
          acc     <= '0;
          cnt     <= '0;
          r_ready <= 1'b1;
          state   <= S_LOAD;
        end
        S_LOAD: if (r_valid) begin
          r_q     <= r_input;
          r_ready <= 1'b0;
          state   <= S_MODMUL;
        end
        S_MODMUL: begin
          y     <= swidth'(rem2);
          state <= S_ACC;
        end
        S_ACC: begin
          // y < q_i so y*qhat_i < Q; the extra CW bits absorb the running sum
          acc <= acc + AW'(y) * AW'(qhat_tab[idx]);
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_REDUCE;
          end else begin
            r_ready <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_REDUCE: begin
          if (acc >= AW'(q_prod)) begin
            acc <= acc - AW'(q_prod);
          end else begin
            a_output <= lwidth'(acc);
            a_valid  <= 1'b1;
            acc      <= '0;
            cnt      <= '0;
            r_ready  <= 1'b1;
            state    <= S_LOAD;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_rns_reconstruct.sv
// Directed + randomized bench for rns_reconstruct with a result scoreboard that also
// tracks the expected a_valid cycle of every operand.
module tb_rns_reconstruct;
  localparam int SW = 8;
  localparam int LW = 32;
  localparam int P  = 4;
  localparam longint QM = 64'd3368562317;
  localparam int QI [P] = '{251, 241, 239, 233};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          r_valid = 1'b0;
  logic [SW-1:0] r_input = '0;
  logic          r_ready;
  logic [LW-1:0] a_output;
  logic          a_valid;

  rns_reconstruct #(.lwidth(LW), .swidth(SW), .parts(P)) dut (
    .clk(clk), .reset(reset), .r_valid(r_valid), .r_input(r_input),
    .r_ready(r_ready), .a_output(a_output), .a_valid(a_valid)
  );

  always #5 clk = ~clk;

  typedef struct { longint val; longint cyc; } exp_t;
  exp_t   exp_q [$];
  int     checks = 0;
  int     passes = 0;
  longint cyc = 0;
  int     acc_cnt = 0;
  logic   prev_av = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Subtraction count the final reduction needs: floor(sum / Q)
  function automatic longint sub_count(input int r [P]);
    longint acc = 0;
    for (int i = 0; i < P; i++) begin
      longint qh = QM / QI[i];
      longint inv = 0;
      for (int j = 1; j < QI[i]; j++)
        if (((qh % QI[i]) * j) % QI[i] == 1) inv = j;
      acc += ((r[i] * inv) % QI[i]) * qh;
    end
    return acc / QM;
  endfunction

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (prev_av) chk("a_valid_single_cycle", a_valid, 1'b0);
    if (a_valid && !prev_av) begin
      if (exp_q.size() == 0) begin
        chk("spurious_a_valid", a_valid, 1'b0);
      end else begin
        exp_t e = exp_q.pop_front();
        chk("a_output", a_output, e.val);
        chk("a_valid_cycle", cyc, e.cyc);
        chk("residues_per_result", acc_cnt, P);
      end
      acc_cnt = 0;
    end
    prev_av = a_valid;
  endtask

  task automatic feed_one(input int v, input bit stress);
    int n = 0;
    bit fired = 0;
    while (!fired && n < 200) begin
      r_valid = stress ? 1'($urandom_range(0, 1)) : 1'b1;
      r_input = SW'(v);
      fired = r_valid && r_ready;
      step();
      n++;
    end
    if (fired) acc_cnt++;
    else chk("handshake_timeout", fired, 1'b1);
  endtask

  task automatic send(input int r [P], input longint val, input bit stress);
    exp_t e;
    for (int i = 0; i < P; i++) feed_one(r[i], stress);
    e.val = val;
    e.cyc = cyc + 3 + sub_count(r);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    r_valid = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int rs [P];
    longint x;

    // reset and INIT timing
    reset = 1'b1;
    step(); step();
    chk("reset_a_output", a_output, 0);
    chk("reset_a_valid", a_valid, 0);
    chk("reset_r_ready", r_ready, 0);
    reset = 1'b0;
    step();
    chk("r_ready_second_cycle", r_ready, 1'b1);

    // directed operands from the plan
    rs = '{0, 0, 0, 0};         send(rs, 0, 1'b0);          drain();
    rs = '{1, 1, 1, 1};         send(rs, 1, 1'b0);          drain();
    rs = '{180, 201, 144, 108}; send(rs, 123456789, 1'b0);  drain();
    rs = '{250, 240, 238, 232}; send(rs, QM - 1, 1'b0);     drain();
    chk("q_minus_1_hold", a_output, QM - 1);

    // back-to-back: next operand's residue 0 is presented throughout MODMUL/ACC/REDUCE
    rs = '{250, 240, 238, 232}; send(rs, QM - 1, 1'b0);
    rs = '{1, 1, 1, 1};         send(rs, 1, 1'b0);
    rs = '{0, 0, 0, 0};         send(rs, 0, 1'b0);
    drain();

    // random operands with random r_valid toggling
    for (int k = 0; k < 12; k++) begin
      x = longint'($urandom) % QM;
      for (int i = 0; i < P; i++) rs[i] = int'(x % QI[i]);
      send(rs, x, 1'b1);
    end
    drain();

    // abort after two residues; nothing may come out for it
    feed_one(7, 1'b0);
    feed_one(9, 1'b0);
    r_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("mid_reset_a_output", a_output, 0);
    chk("mid_reset_r_ready", r_ready, 0);
    step();
    chk("mid_reset_a_valid", a_valid, 0);
    reset = 1'b0;
    acc_cnt = 0;
    rs = '{1, 1, 1, 1}; send(rs, 1, 1'b0);
    drain();
    chk("after_abort_a_output", a_output, 1);

    // stall in LOAD holds the result
    for (int k = 0; k < 10; k++) step();
    chk("stall_r_ready", r_ready, 1'b1);
    chk("stall_a_output_hold", a_output, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
